// File: rtl/str_usmul.sv
// Unsigned shift-add multiplier pipeline: out_product = multiplicand * multiplier (+ addend).
// Latency DW cycles, one transfer per cycle; each stage adds the shifted multiplicand for one multiplier bit.
// Optional macro STR_USMUL_ADDEND_EN seeds the accumulator with in_addend; otherwise in_addend is ignored.
module str_usmul #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   in_multiplicand,
  input  logic [DW-1:0]   in_multiplier,
  input  logic [DW-1:0]   in_addend,
  input  logic            in_last,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [2*DW-1:0] out_product,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready
);

  // Per-stage registered state
  logic [2*DW-1:0] acc_q    [DW];
  logic [2*DW-1:0] acc_d    [DW];
  logic [DW-1:0]   mcand_q  [DW];
  logic [DW-1:0]   mcand_d  [DW];
  logic [DW-1:0]   mplier_q [DW];
  logic [DW-1:0]   mplier_d [DW];
  logic [DW-1:0]   last_q, last_d;
  logic [DW-1:0]   vld_q, vld_d;

  // Per-stage inputs (from the ports for stage 0, from the previous stage otherwise)
  logic [2*DW-1:0] stg_acc_in [DW];
  logic [DW-1:0]   stg_mc_in  [DW];
  logic [DW-1:0]   stg_mp_in  [DW];
  logic [DW-1:0]   stg_last_in;
  logic [DW-1:0]   stg_vld_in;

  // Backward ready chain
  logic [DW-1:0]   stg_irdy;
  logic [DW-1:0]   stg_ordy;
  logic            rdy_chain;

  logic [2*DW-1:0] acc_seed;

`ifdef STR_USMUL_ADDEND_EN
  assign acc_seed = {{DW{1'b0}}, in_addend};
`else
  assign acc_seed = '0;
`endif

  // The last stage's operand copies are not consumed, and in_addend is idle when the addend is disabled.
  logic unused_sink;
  assign unused_sink = ^{mcand_q[DW-1], mplier_q[DW-1], in_addend};

  assign stg_last_in = {last_q[DW-2:0], in_last};
  assign stg_vld_in  = {vld_q[DW-2:0], in_valid};

  // Route each stage's upstream data: ports into stage 0, stage i-1 into stage i
  always_comb begin
    stg_acc_in[0] = acc_seed;
    stg_mc_in[0]  = in_multiplicand;
    stg_mp_in[0]  = in_multiplier;
    for (int i = 1; i < DW; i++) begin
      stg_acc_in[i] = acc_q[i-1];
      stg_mc_in[i]  = mcand_q[i-1];
      stg_mp_in[i]  = mplier_q[i-1];
    end
  end

  // Ready ripples from the output back to stage 0: a stage can load if empty or draining this cycle
  always_comb begin
    stg_irdy  = '0;
    stg_ordy  = '0;
    rdy_chain = out_ready;
    for (int i = DW - 1; i >= 0; i--) begin
      stg_ordy[i] = rdy_chain;
      rdy_chain   = ~vld_q[i] | rdy_chain;
      stg_irdy[i] = rdy_chain;
    end
  end

  // Next state: load on input handshake (adding the shifted multiplicand for bit i), else hold
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    last_d   = last_q;
    vld_d    = vld_q;
    for (int i = 0; i < DW; i++) begin
      if (stg_vld_in[i] && stg_irdy[i]) begin
        vld_d[i]    = 1'b1;
        mcand_d[i]  = stg_mc_in[i];
        mplier_d[i] = stg_mp_in[i];
        last_d[i]   = stg_last_in[i];
        if (stg_mp_in[i][i]) begin
          acc_d[i] = stg_acc_in[i] + ({{DW{1'b0}}, stg_mc_in[i]} << i);
        end else begin
          acc_d[i] = stg_acc_in[i];
        end
      end else if (stg_ordy[i]) begin
        vld_d[i] = 1'b0;
      end
    end
  end

  // Stage registers with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DW; i++) begin
        acc_q[i]    <= '0;
        mcand_q[i]  <= '0;
        mplier_q[i] <= '0;
      end
      last_q <= '0;
      vld_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      last_q   <= last_d;
      vld_q    <= vld_d;
    end
  end

  assign in_ready    = stg_irdy[0];
  assign out_product = acc_q[DW-1];
  assign out_last    = last_q[DW-1];
  assign out_valid   = vld_q[DW-1];

endmodule

// File: tb/tb_str_usmul.sv
// Bench for str_usmul: scoreboard of expected products against the DUT stream,
// plus directed literal cases, pipeline fill, mid-flight reset and random backpressure.
module tb_str_usmul;
  localparam int DW = 8;
`ifdef STR_USMUL_ADDEND_EN
  localparam bit ADD_EN = 1'b1;
`else
  localparam bit ADD_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   in_multiplicand = '0;
  logic [DW-1:0]   in_multiplier = '0;
  logic [DW-1:0]   in_addend = '0;
  logic            in_last = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2*DW-1:0] out_product;
  logic            out_last;
  logic            out_valid;
  logic            out_ready = 1'b1;

  always #5 clk = ~clk;

  str_usmul #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_multiplicand(in_multiplicand), .in_multiplier(in_multiplier),
    .in_addend(in_addend), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_product(out_product), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [2*DW-1:0] prod;
    logic            last;
    int              cyc;
  } exp_t;

  exp_t            q[$];
  int              n_tests = 0;
  int              n_fail = 0;
  int              cyc = 0;
  int              n_in = 0;
  int              n_out = 0;
  int              n_disc = 0;
  bit              strict_lat = 1'b0;
  logic            rst_prev = 1'b0;
  bit              prev_stall = 1'b0;
  logic [2*DW-1:0] prev_prod = '0;
  logic            prev_last = 1'b0;

  function automatic logic [2*DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] c);
    logic [2*DW-1:0] r;
    r = (2*DW)'(a) * (2*DW)'(b);
    r = r + (ADD_EN ? (2*DW)'(c) : (2*DW)'(0));
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every negedge, check reset state, stall stability, outputs, and record inputs
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      n_disc     = n_disc + q.size();
      q.delete();
      prev_stall = 1'b0;
      if (rst_prev) begin
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_product", 64'(out_product), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
      end
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_product", 64'(out_product), 64'(prev_prod));
        chk("stall_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          chk("unexpected_output", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          chk("sb_product", 64'(out_product), 64'(e.prod));
          chk("sb_last", 64'(out_last), 64'(e.last));
          if (strict_lat) chk("sb_latency", 64'(cyc - e.cyc), 64'(DW));
        end
      end
      if (in_valid && in_ready) begin
        e.prod = model(in_multiplicand, in_multiplier, in_addend);
        e.last = in_last;
        e.cyc  = cyc;
        q.push_back(e);
        n_in++;
      end
      prev_stall = out_valid && !out_ready;
      prev_prod  = out_product;
      prev_last  = out_last;
    end
    rst_prev = rst;
  end

  task automatic rnd_in();
    in_multiplicand = DW'($urandom);
    in_multiplier   = DW'($urandom);
    in_addend       = DW'($urandom);
    in_last         = 1'($urandom);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d transfers pending after %0d cycles, expected 0", nm, q.size(), k);
    end
  endtask

  // One isolated transfer with out_ready=1; checks latency, literal result and a single-cycle pulse
  task automatic send(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] c, input logic l, input logic [2*DW-1:0] exp_p);
    int k = 0;
    @(posedge clk); #1;
    in_multiplicand = a; in_multiplier = b; in_addend = c; in_last = l;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (k < 30) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
    end
    chk({nm, "_latency"}, 64'(k), 64'(DW));
    chk({nm, "_product"}, 64'(out_product), 64'(exp_p));
    chk({nm, "_last"}, 64'(out_last), 64'(l));
    @(negedge clk);
    chk({nm, "_pulse"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    int acc;
    int k;
    int start;

    // Pin the model against hand-computed values
    chk("model_13_11_7", 64'(model(13, 11, 7)), ADD_EN ? 64'd150 : 64'd143);
    chk("model_ff", 64'(model(8'd255, 8'd255, 8'd255)), ADD_EN ? 64'd65280 : 64'd65025);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed literal cases
    strict_lat = 1'b1;
    send("lit_13_11_7", 8'd13, 8'd11, 8'd7, 1'b1, ADD_EN ? 16'h0096 : 16'd143);
    send("lit_ff", 8'd255, 8'd255, 8'd255, 1'b0, ADD_EN ? 16'hFF00 : 16'hFE01);
    send("lit_0_200_9", 8'd0, 8'd200, 8'd9, 1'b0, ADD_EN ? 16'd9 : 16'd0);
    send("lit_1_1_0", 8'd1, 8'd1, 8'd0, 1'b1, 16'd1);

    // Back-to-back stream of 100 with out_ready=1: full throughput, exact latency
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rnd_in();
      in_valid = 1'b1;
      @(negedge clk);
      chk("stream_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("stream_drain");
    strict_lat = 1'b0;

    // Fill with out_ready=0: exactly DW accepted, then in_ready low
    @(posedge clk); #1;
    out_ready = 1'b0;
    rnd_in();
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!in_ready) break;
      acc++;
      @(posedge clk); #1;
      rnd_in();
    end
    chk("fill_accepted", 64'(acc), 64'(DW));
    repeat (2) begin
      @(negedge clk);
      chk("fill_in_ready_low", 64'(in_ready), 64'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("fill_drain");

    // Random valid/ready over 1000 transfers
    start = n_in;
    k = 0;
    while (n_in - start < 1000 && k < 20000) begin
      @(posedge clk); #1;
      rnd_in();
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      k++;
    end
    chk("random_accepted", 64'(n_in - start >= 1000), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("random_drain");

    // Reset with 4 transfers in flight
    strict_lat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rnd_in();
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 64'(out_valid), 64'(0));
    end
    chk("rst_discarded", 64'(n_disc), 64'(4));
    send("post_rst", 8'd200, 8'd3, 8'd5, 1'b1, ADD_EN ? 16'd605 : 16'd600);

    chk("conservation", 64'(n_in), 64'(n_out + n_disc));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/str_usmul.md
STR_USMUL -- requirements
Module: str_usmul

Interface
REQ-001 Parameter: DW, default 8, operand width in bits (DW >= 2).
REQ-002 Port: clk  input  1  clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_multiplicand  input  DW  unsigned multiplicand.
REQ-005 Port: in_multiplier  input  DW  unsigned multiplier.
REQ-006 Port: in_addend  input  DW  unsigned addend (remainder-style term).
REQ-007 Port: in_last  input  1  end-of-packet marker, carried unchanged alongside the data.
REQ-008 Port: in_valid  input  1  upstream data valid.
REQ-009 Port: in_ready  output  1  block accepts input this cycle.
REQ-010 Port: out_product  output  2*DW  result, multiplicand*multiplier (+ addend).
REQ-011 Port: out_last  output  1  in_last of the same transfer.
REQ-012 Port: out_valid  output  1  output data valid.
REQ-013 Port: out_ready  input  1  downstream accepts output.

Function
REQ-014 The block SHALL be a pipeline of exactly DW register stages; stage i (0..DW-1) consumes multiplier bit i, LSB first.
REQ-015 Each stage SHALL carry: accumulator (2*DW), multiplicand (DW), multiplier (DW), last (1), valid (1).
REQ-016 Stage 0 SHALL receive accumulator = zero-extended in_addend (REQ-031/032 govern this).
REQ-017 Stage i SHALL register accumulator + (zero-extended multiplicand << i) when multiplier bit i = 1, otherwise the accumulator unchanged.
REQ-018 Arithmetic SHALL be modulo 2^(2*DW); the maximum result (2^DW-1)^2 + (2^DW-1) = 2^(2*DW) - 2^DW fits, so overflow cannot occur.
REQ-019 Per stage: input handshake = stage in_valid & stage in_ready; output handshake = stage out_valid & stage out_ready.
REQ-020 Per stage: in_ready = output handshake | ~out_valid (combinational backward ready chain).
REQ-021 Per stage out_valid: set to 1 on input handshake; else cleared to 0 when out_ready = 1; else held.
REQ-022 Per stage data registers SHALL load only on input handshake and SHALL hold otherwise.
REQ-023 A full stage with simultaneous input and output handshake SHALL pass its old contents downstream and load the new transfer in the same cycle, with no bubble.
REQ-024 With out_ready held at 1, latency SHALL be DW cycles (in_valid at edge n -> out_valid at edge n+DW) and throughput one transfer per cycle.
REQ-025 While out_valid = 1 and out_ready = 0, out_product and out_last SHALL remain stable.
REQ-026 Input bubbles (in_valid = 0) SHALL propagate as invalid stages; transfer order SHALL be preserved and none SHALL be dropped or duplicated.
REQ-027 A full pipeline with out_ready = 0 SHALL hold exactly DW transfers and deassert in_ready.

Reset
REQ-028 While rst = 1, every stage valid SHALL be 0, and accumulator, multiplicand, multiplier and last SHALL be 0; out_valid = 0, out_product = 0, out_last = 0.
REQ-029 in_ready SHALL read 1 during and after reset (all stages empty).
REQ-030 Reset asserted mid-operation SHALL discard all in-flight transfers, with no output produced for them after rst falls.

Configuration
REQ-031 Macro STR_USMUL_ADDEND_EN defined: stage 0 accumulator input = {DW'0, in_addend}; out_product = multiplicand*multiplier + addend (exact inverse of unsigned division: quotient*divisor + remainder = dividend).
REQ-032 Macro STR_USMUL_ADDEND_EN undefined: in_addend port SHALL remain but be ignored; stage 0 accumulator input = 0; out_product = multiplicand*multiplier.

Verification
REQ-033 DW=8, ADDEND_EN, out_ready=1: in (13, 11, 7, last=1) -> exactly 8 cycles later out_product=150 (0x0096), out_last=1, out_valid pulses 1 cycle.
REQ-034 DW=8, ADDEND_EN: (255, 255, 255) -> 65280 (0xFF00); (0, 200, 9) -> 9; without macro, (255, 255, 255) -> 65025 (0xFE01).
REQ-035 Back-to-back stream of 100 random operand sets, out_ready=1 -> 100 results in order, one per cycle, each equal to the reference model.
REQ-036 Random out_ready (50%) and in_valid (50%) over 1000 transfers -> no loss, duplication or reordering; outputs stable whenever out_valid=1 & out_ready=0.
REQ-037 out_ready=0 with in_valid=1 -> in_ready falls after exactly 8 accepted transfers; release -> all 8 delivered in order.
REQ-038 rst pulsed with 4 transfers in flight -> out_valid=0 for the following 8 cycles with no new input; the next transfer yields a correct result at latency 8.
